// File: rtl/led_sequence_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_sequence_player_pkg
//  Purpose  : Shared definitions for the LED sequence player peripheral:
//             register offsets, control/status bit positions, colour codes
//             and the playback state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package led_sequence_player_pkg;

    // Word offsets inside the register window
    localparam logic [11:0] c_OFS_PUSH   = 12'd0;
    localparam logic [11:0] c_OFS_CTRL   = 12'd1;
    localparam logic [11:0] c_OFS_STATUS = 12'd2;

    // CTRL write bits
    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_CLEAR = 1;

    // STATUS read bits / fields
    localparam int c_ST_BUSY     = 0;
    localparam int c_ST_DONE     = 1;
    localparam int c_ST_OVERFLOW = 2;
    localparam int c_ST_EMPTY    = 3;
    localparam int c_ST_LEN_LSB  = 4;
    localparam int c_ST_IDX_LSB  = 12;
    localparam int c_ST_FIELD_W  = 5;

    // Colour codes as stored in the sequence buffer
    localparam logic [1:0] c_COLOUR_0 = 2'd0;
    localparam logic [1:0] c_COLOUR_1 = 2'd1;
    localparam logic [1:0] c_COLOUR_2 = 2'd2;
    localparam logic [1:0] c_COLOUR_3 = 2'd3;

    // Playback state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } play_state_t;

    // Colour code to one-hot LED pattern
    function automatic logic [3:0] colour_onehot(input logic [1:0] colour);
        return 4'b0001 << colour;
    endfunction

endpackage : led_sequence_player_pkg
`default_nettype wire

// File: rtl/led_sequence_player_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_sequence_player_if
//  Purpose  : CPU data-memory bus slice seen by the LED sequence player
//             (write enable, word address, write data, read data).
//  Revision : 1.0  initial release
// ============================================================================
interface led_sequence_player_if;

    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (output wEn, output addr, output dataIn, input  dataOut);
    modport slave  (input  wEn, input  addr, input  dataIn, output dataOut);

endinterface : led_sequence_player_if
`default_nettype wire

// File: rtl/led_sequence_player_seq_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : led_sequence_player_seq_buffer
//  Purpose  : DEPTH x 2-bit colour store; synchronous write, asynchronous
//             read. Contents are deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module led_sequence_player_seq_buffer #(
    parameter int DEPTH = 16
) (
    input  wire logic                       clock,
    input  wire logic                       i_we,
    input  wire logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  wire logic [1:0]                 i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic      [1:0]                 o_rdata
);

    logic [1:0] r_mem [DEPTH];

    // Store an appended colour code
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : led_sequence_player_seq_buffer
`default_nettype wire

// File: rtl/led_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : led_sequence_player
//  Purpose  : Memory-mapped peripheral that buffers colour codes written by
//             the CPU and replays them on four one-hot LEDs with fixed on
//             and gap timing. Holds the playback FSM, counters, bus decode.
//  Revision : 1.0  initial release
// ============================================================================
module led_sequence_player
    import led_sequence_player_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          ON_CYCLES  = 25000000,
    parameter int          GAP_CYCLES = 12500000,
    parameter logic [11:0] BASE_ADDR  = 12'hF00
) (
    input  wire logic            clock,
    input  wire logic            reset,
    led_sequence_player_if.slave bus,
    output logic [3:0]           led,
    output logic                 busy
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_LEN_W   = $clog2(DEPTH) + 1;
    localparam int c_MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [11:0]        c_ADDR_PUSH   = BASE_ADDR + c_OFS_PUSH;
    localparam logic [11:0]        c_ADDR_CTRL   = BASE_ADDR + c_OFS_CTRL;
    localparam logic [11:0]        c_ADDR_STATUS = BASE_ADDR + c_OFS_STATUS;
    localparam logic [c_CNT_W-1:0] c_ON_LAST     = c_CNT_W'(ON_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST    = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_LEN_W-1:0] c_FULL        = c_LEN_W'(DEPTH);

    play_state_t          r_state, w_state_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [c_LEN_W-1:0]   r_idx, w_idx_next;
    logic [c_LEN_W-1:0]   r_len, w_len_next;
    logic [c_LEN_W-1:0]   r_play_len, w_play_len_next;
    logic                 r_done, w_done_next;
    logic                 r_overflow, w_overflow_next;
    logic [3:0]           r_led, w_led_next;
    logic [31:0]          r_data_out;
    logic [31:0]          w_status;
    logic                 w_wr_push, w_wr_ctrl, w_push_we;
    logic                 w_start, w_clear;
    logic [1:0]           w_rd_colour;
    logic                 w_unused;

    assign w_wr_push = bus.wEn && (bus.addr == c_ADDR_PUSH);
    assign w_wr_ctrl = bus.wEn && (bus.addr == c_ADDR_CTRL);
    assign w_start   = w_wr_ctrl && bus.dataIn[c_CTRL_START];
    assign w_clear   = w_wr_ctrl && bus.dataIn[c_CTRL_CLEAR];
    assign w_unused  = &{1'b0, bus.dataIn[31:2]};

    // Colour store; read address follows the next index so the registered
    // LED pattern lands on the same edge as the state change.
    led_sequence_player_seq_buffer #(
        .DEPTH (DEPTH)
    ) u_seq_buffer (
        .clock   (clock),
        .i_we    (w_push_we & ~reset),
        .i_waddr (r_len[c_ADDR_W-1:0]),
        .i_wdata (bus.dataIn[1:0]),
        .i_raddr (w_idx_next[c_ADDR_W-1:0]),
        .o_rdata (w_rd_colour)
    );

    // Next-state: buffer append, playback sequencing, CLEAR override
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_idx_next      = r_idx;
        w_len_next      = r_len;
        w_play_len_next = r_play_len;
        w_done_next     = r_done;
        w_overflow_next = r_overflow;
        w_push_we       = 1'b0;

        if (w_wr_push) begin
            if (r_len == c_FULL) begin
                w_overflow_next = 1'b1;
            end else begin
                w_push_we  = 1'b1;
                w_len_next = r_len + c_LEN_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_done_next     = 1'b0;
                    w_play_len_next = r_len;
                    if (r_len != '0) begin
                        w_state_next = ST_ON;
                        w_idx_next   = '0;
                        w_cnt_next   = '0;
                    end else begin
                        w_done_next  = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (r_cnt == c_ON_LAST) begin
                    w_state_next = ST_GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + c_CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_next = '0;
                    if (r_idx == r_play_len - c_LEN_W'(1)) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_idx_next   = r_idx + c_LEN_W'(1);
                        w_state_next = ST_ON;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // CLEAR aborts playback and empties the buffer; it outranks START
        if (w_clear) begin
            w_state_next    = ST_IDLE;
            w_cnt_next      = '0;
            w_idx_next      = '0;
            w_len_next      = '0;
            w_overflow_next = 1'b0;
            w_done_next     = 1'b0;
        end
    end

    // LED pattern for the state being entered (kept apart from the FSM
    // block because it depends on the buffer read of the next index)
    always_comb begin
        w_led_next = '0;
        if (w_state_next == ST_ON) begin
            w_led_next = colour_onehot(w_rd_colour);
        end
    end

    // Status word from current register values
    always_comb begin
        w_status                                   = '0;
        w_status[c_ST_BUSY]                        = (r_state != ST_IDLE);
        w_status[c_ST_DONE]                        = r_done;
        w_status[c_ST_OVERFLOW]                    = r_overflow;
        w_status[c_ST_EMPTY]                       = (r_len == '0);
        w_status[c_ST_LEN_LSB +: c_ST_FIELD_W]     = c_ST_FIELD_W'(r_len);
        w_status[c_ST_IDX_LSB +: c_ST_FIELD_W]     = c_ST_FIELD_W'(r_idx);
    end

    // State, counter and LED registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_play_len <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_led      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_len      <= w_len_next;
            r_play_len <= w_play_len_next;
            r_done     <= w_done_next;
            r_overflow <= w_overflow_next;
            r_led      <= w_led_next;
        end
    end

    // Registered read port: STATUS inside the window, zero elsewhere
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (bus.addr == c_ADDR_STATUS) begin
            r_data_out <= w_status;
        end else begin
            r_data_out <= '0;
        end
    end

    assign bus.dataOut = r_data_out;
    assign led         = r_led;
    assign busy        = (r_state != ST_IDLE);

endmodule : led_sequence_player
`default_nettype wire

// File: tb/tb_led_sequence_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_sequence_player
//  Purpose  : Self-checking bench for led_sequence_player. A time-based
//             reference model predicts LEDs, busy and read data each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_sequence_player;

    localparam int          c_ON     = 4;
    localparam int          c_GAP    = 2;
    localparam int          c_PERIOD = c_ON + c_GAP;
    localparam int          c_DEPTH  = 16;
    localparam logic [11:0] c_PUSH   = 12'hF00;
    localparam logic [11:0] c_CTRL   = 12'hF01;
    localparam logic [11:0] c_STAT   = 12'hF02;

    logic       clock;
    logic       reset;
    logic [3:0] led;
    logic       busy;

    led_sequence_player_if bus ();

    led_sequence_player #(
        .DEPTH      (c_DEPTH),
        .ON_CYCLES  (c_ON),
        .GAP_CYCLES (c_GAP),
        .BASE_ADDR  (12'hF00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .led   (led),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: sequence contents plus elapsed time since START
    int          m_buf [c_DEPTH];
    int          m_len, m_plen, m_t, m_idx;
    bit          m_ovf, m_done, m_play;
    logic [31:0] m_dout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_led();
        if (!m_play) return 4'd0;
        if ((m_t % c_PERIOD) < c_ON) return 4'(1 << m_buf[m_t / c_PERIOD]);
        return 4'd0;
    endfunction

    function automatic int exp_idx();
        return m_play ? (m_t / c_PERIOD) : m_idx;
    endfunction

    function automatic logic [31:0] exp_status();
        return {15'd0, 5'(exp_idx()), 3'd0, 5'(m_len), (m_len == 0), m_ovf, m_done, m_play};
    endfunction

    task automatic model_edge(input bit rst, input bit we, input logic [11:0] a, input logic [31:0] d);
        bit was;
        if (rst) begin
            m_len = 0; m_plen = 0; m_t = 0; m_idx = 0;
            m_ovf = 0; m_done = 0; m_play = 0; m_dout = '0;
            return;
        end
        m_dout = (a == c_STAT) ? exp_status() : 32'd0;
        was = m_play;
        if (was) begin
            m_t++;
            if (m_t == m_plen * c_PERIOD) begin
                m_play = 0;
                m_done = 1;
                m_idx  = m_plen - 1;
            end
        end
        if (we && a == c_CTRL) begin
            if (d[1]) begin
                m_len = 0; m_ovf = 0; m_done = 0; m_play = 0; m_idx = 0;
            end else if (d[0] && !was) begin
                m_done = 0;
                m_plen = m_len;
                if (m_len > 0) begin
                    m_play = 1;
                    m_t    = 0;
                end else begin
                    m_done = 1;
                end
            end
        end
        if (we && a == c_PUSH) begin
            if (m_len == c_DEPTH) m_ovf = 1;
            else begin
                m_buf[m_len] = int'(d[1:0]);
                m_len++;
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance model, compare
    task automatic step(input bit rst, input bit we, input logic [11:0] a, input logic [31:0] d);
        reset      = rst;
        bus.wEn    = we;
        bus.addr   = a;
        bus.dataIn = d;
        @(posedge clock);
        model_edge(rst, we, a, d);
        #1;
        check_val("led",     {28'd0, led},  {28'd0, exp_led()});
        check_val("busy",    {31'd0, busy}, {31'd0, m_play});
        check_val("dataOut", bus.dataOut,   m_dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, c_STAT, 32'd0);
    endtask

    task automatic push(input int colour);
        step(0, 1, c_PUSH, 32'(colour) | ({$urandom} & 32'hFFFF_FFFC));
    endtask

    initial begin
        reset      = 1'b1;
        bus.wEn    = 1'b0;
        bus.addr   = 12'd0;
        bus.dataIn = 32'd0;
        foreach (m_buf[i]) m_buf[i] = 0;

        // Reset state
        step(1, 0, c_STAT, 32'd0);
        step(1, 0, c_STAT, 32'd0);
        step(0, 0, c_STAT, 32'd0);
        check_val("reset_status", bus.dataOut, 32'h0000_0008);

        // Three-element playback
        push(2); push(0); push(3);
        step(0, 1, c_CTRL, 32'h1);
        check_val("first_led", {28'd0, led}, 32'h4);
        idle(3 * c_PERIOD + 2);
        check_val("play3_status", bus.dataOut, 32'h0000_2032);

        // Overflow: 17 pushes, replay 16
        step(0, 1, c_CTRL, 32'h2);
        for (int i = 0; i < 17; i++) push(int'($urandom_range(0, 3)));
        step(0, 1, c_CTRL, 32'h1);
        idle(c_DEPTH * c_PERIOD + 3);

        // CLEAR during second ON
        step(0, 1, c_CTRL, 32'h1);
        idle(c_PERIOD + 1);
        step(0, 1, c_CTRL, 32'h3);
        step(0, 0, c_STAT, 32'd0);
        check_val("clear_status", bus.dataOut, 32'h0000_0008);

        // START on empty buffer, then START while busy
        step(0, 1, c_CTRL, 32'h1);
        idle(3);
        push(1); push(3);
        step(0, 1, c_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) step(0, 1, c_CTRL, 32'h1);
        idle(2 * c_PERIOD);

        // PUSH during GAP of a two-element play, then reset mid-ON
        step(0, 1, c_CTRL, 32'h2);
        push(0); push(2);
        step(0, 1, c_CTRL, 32'h1);
        idle(c_ON);
        push(1);
        idle(2 * c_PERIOD + 2);
        step(0, 1, c_CTRL, 32'h1);
        idle(2);
        step(1, 0, c_STAT, 32'd0);
        check_val("reset_led", {28'd0, led}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 30)       push(int'($urandom_range(0, 3)));
            else if (r < 40)  step(0, 1, c_CTRL, 32'h1);
            else if (r < 42)  step(0, 1, c_CTRL, {$urandom} | 32'h2);
            else if (r < 46)  step(0, 1, c_STAT, $urandom);
            else if (r < 50)  step(0, 1, 12'(c_PUSH + 12'(3 + $urandom_range(0, 60))), $urandom);
            else if (r == 50) step(1, 0, c_STAT, 32'd0);
            else if (r < 120) step(0, 0, c_STAT, 32'd0);
            else              step(0, 0, 12'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_led_sequence_player
`default_nettype wire
